// File: rtl/control_sequencer.sv
// control_sequencer -- microcoded control FSM for a small accumulator CPU.
//
// Each instruction is fetched in F0..F2, decoded in DEC and run in zero to
// three execute states (E0..E2). Every control output is decoded
// combinationally from the state register and the opcode latched in DEC.
// The only exception is the JZ branch, which also looks at Z.
//
// Ports:
//   clk          system clock, rising edge active
//   rst          asynchronous, active-low reset
//   instruction  5-bit opcode from IR, valid in DEC
//   Z            zero flag (used only by JZ)
//   ir_sclr, mar_sclr            synchronous clears of IR / MAR
//   enaf                         flag-register update enable
//   selop[2:0]                   ALU operation
//   shamt[1:0]                   shift amount, tied to zero
//   bank_wr_en                   register-bank write enable
//   busB_addr[2:0], busC_addr[2:0]  bank read / write addresses
//   ir_en, mar_en, mdr_en        IR / MAR / MDR load enables
//   wr_rdn                       memory write (1) / read (0)
//   mdr_alu_n                    busC source: MDR (1) / ALU (0)
//   state_m[3:0]                 current state, for monitoring
//   halted                       high while in HALT
//
// Build option: define CTRL_SEQ_BRANCH_EN to add JZ DPTR (opcode 00101).
// Without it, 00101 behaves as a NOP.

module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instruction,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       mdr_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic [3:0] state_m,
  output logic       halted
);

  // Register-bank addresses
  localparam logic [2:0] REG_PC   = 3'b000;
  localparam logic [2:0] REG_DPTR = 3'b010;
  localparam logic [2:0] REG_A    = 3'b011;
  localparam logic [2:0] REG_ACC  = 3'b111;

  // ALU operations
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_INC_B  = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;

  // Opcodes
  localparam logic [4:0] OP_LD_ACC  = 5'b00001;  // MOV ACC,[DPTR]
  localparam logic [4:0] OP_ST_ACC  = 5'b00010;  // MOV [DPTR],ACC
  localparam logic [4:0] OP_MOV_A   = 5'b00011;  // MOV ACC,A
  localparam logic [4:0] OP_ADD_A   = 5'b00100;  // ADD ACC,A
  localparam logic [4:0] OP_JZ      = 5'b00101;  // JZ DPTR
  localparam logic [4:0] OP_HALT    = 5'b11111;

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] op_reg;

  // Opcodes that need at least one execute state. Everything else is a NOP.
  function automatic logic has_exec(input logic [4:0] op);
    logic r;
    r = (op == OP_LD_ACC) || (op == OP_ST_ACC) ||
        (op == OP_MOV_A)  || (op == OP_ADD_A);
`ifdef CTRL_SEQ_BRANCH_EN
    r = r || (op == OP_JZ);
`endif
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_INIT;
      op_reg    <= 5'b00000;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DEC) op_reg <= instruction;
    end
  end

  // Next-state logic. DEC branches on the live IR value, because op_reg
  // only holds that opcode from E0 onwards.
  always_comb begin
    state_next = S_INIT;
    case (state_reg)
      S_INIT: state_next = S_F0;
      S_F0:   state_next = S_F1;
      S_F1:   state_next = S_F2;
      S_F2:   state_next = S_DEC;
      S_DEC: begin
        if (instruction == OP_HALT)     state_next = S_HALT;
        else if (has_exec(instruction)) state_next = S_E0;
        else                            state_next = S_F0;
      end
      S_E0: begin
        if (op_reg == OP_LD_ACC || op_reg == OP_ST_ACC) state_next = S_E1;
        else                                            state_next = S_F0;
      end
      S_E1:   state_next = S_E2;
      S_E2:   state_next = S_F0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    ir_sclr    = 1'b0;
    mar_sclr   = 1'b0;
    enaf       = 1'b0;
    selop      = ALU_PASS_B;
    bank_wr_en = 1'b0;
    busB_addr  = REG_PC;
    busC_addr  = REG_PC;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    wr_rdn     = 1'b0;
    mdr_alu_n  = 1'b0;
    case (state_reg)
      S_INIT: begin
        ir_sclr  = 1'b1;
        mar_sclr = 1'b1;
      end
      S_F0: mar_en = 1'b1;                      // MAR <= PC
      S_F1: mdr_en = 1'b1;                      // MDR <= mem[MAR]
      S_F2: begin                               // IR <= MDR, PC <= PC + 1
        ir_en      = 1'b1;
        selop      = ALU_INC_B;
        bank_wr_en = 1'b1;
      end
      S_E0: begin
        case (op_reg)
          OP_LD_ACC, OP_ST_ACC: begin
            busB_addr = REG_DPTR;
            mar_en    = 1'b1;
          end
          OP_MOV_A: begin
            busB_addr  = REG_A;
            busC_addr  = REG_ACC;
            bank_wr_en = 1'b1;
          end
          OP_ADD_A: begin
            busB_addr  = REG_ACC;
            selop      = ALU_ADD;
            enaf       = 1'b1;
            busC_addr  = REG_ACC;
            bank_wr_en = 1'b1;
          end
`ifdef CTRL_SEQ_BRANCH_EN
          OP_JZ: begin
            // Branch taken: PC <= DPTR. Not taken: this is an idle cycle.
            if (Z) begin
              busB_addr  = REG_DPTR;
              busC_addr  = REG_PC;
              bank_wr_en = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      S_E1: begin
        mdr_en = 1'b1;
        if (op_reg == OP_ST_ACC) busB_addr = REG_ACC;  // MDR <= ACC via ALU
      end
      S_E2: begin
        if (op_reg == OP_LD_ACC) begin
          mdr_alu_n  = 1'b1;
          busC_addr  = REG_ACC;
          bank_wr_en = 1'b1;
        end else begin
          wr_rdn = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifndef CTRL_SEQ_BRANCH_EN
  // Z only matters for JZ.
  logic unused_z;
  assign unused_z = Z;
`endif

  assign shamt   = 2'b00;
  assign state_m = state_reg;
  assign halted  = (state_reg == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A table-level model expands each
// opcode into the list of per-cycle control words it should produce.
// Randomised and directed instructions are then checked cycle by cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] instruction = 5'b0;
  logic       Z = 1'b0;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted;
  logic [3:0] state_m;

  control_sequencer dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Z(Z),
    .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
    .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
    .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
    .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .state_m(state_m), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_sclr, mar_sclr, enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busb, busc;
    logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n;
    logic [3:0] state;
    logic       halted;
  } outs_t;

  outs_t got;
  assign got = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr,
                busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, state_m, halted};

  int    checks = 0;
  int    errors = 0;
  outs_t seq[$];

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%07h exp=%07h", tag, got_v, exp_v);
    end
  endtask

  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  // Expected control words for one instruction, F0 up to the last state
  // before the next F0 (or 20 cycles of HALT).
  task automatic build_seq(input logic [4:0] op, input logic z);
    outs_t o;
    seq.delete();
    o = blank(1); o.mar_en = 1;                                   seq.push_back(o);
    o = blank(2); o.mdr_en = 1;                                   seq.push_back(o);
    o = blank(3); o.ir_en = 1; o.selop = 3'd1; o.bank_wr_en = 1;  seq.push_back(o);
    o = blank(4);                                                 seq.push_back(o);
    case (op)
      5'd1: begin
        o = blank(5); o.busb = 3'd2; o.mar_en = 1; seq.push_back(o);
        o = blank(6); o.mdr_en = 1;                seq.push_back(o);
        o = blank(7); o.mdr_alu_n = 1; o.busc = 3'd7; o.bank_wr_en = 1; seq.push_back(o);
      end
      5'd2: begin
        o = blank(5); o.busb = 3'd2; o.mar_en = 1; seq.push_back(o);
        o = blank(6); o.busb = 3'd7; o.mdr_en = 1; seq.push_back(o);
        o = blank(7); o.wr_rdn = 1;                seq.push_back(o);
      end
      5'd3: begin
        o = blank(5); o.busb = 3'd3; o.busc = 3'd7; o.bank_wr_en = 1; seq.push_back(o);
      end
      5'd4: begin
        o = blank(5); o.busb = 3'd7; o.selop = 3'd2; o.enaf = 1;
        o.busc = 3'd7; o.bank_wr_en = 1; seq.push_back(o);
      end
`ifdef CTRL_SEQ_BRANCH_EN
      5'd5: begin
        o = blank(5);
        if (z) begin o.busb = 3'd2; o.busc = 3'd0; o.bank_wr_en = 1; end
        seq.push_back(o);
      end
`endif
      5'd31: begin
        for (int k = 0; k < 20; k++) begin
          o = blank(8); o.halted = 1; seq.push_back(o);
        end
      end
      default: ;
    endcase
  endtask

  // Runs one instruction. With abort_at >= 0, it stops after that cycle's
  // check and applies reset in the same cycle.
  task automatic run_instr(input logic [4:0] op, input logic z, input int abort_at);
    build_seq(op, z);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("op%02h_cyc%0d_st%0d", op, i, seq[i].state), 32'(got), 32'(seq[i]));
      if (i == 0) begin
        instruction = op;
        Z = z;
      end
      if (i == abort_at) begin
        do_reset();
        return;
      end
    end
  endtask

  // Asserts reset asynchronously, checks the reset outputs at once, then
  // releases reset just after a rising edge so that the next cycle is INIT.
  task automatic do_reset();
    outs_t r;
    r = blank(0); r.ir_sclr = 1; r.mar_sclr = 1;
    rst = 1'b0;
    #1;
    check_eq("reset_async", 32'(got), 32'(r));
    @(posedge clk);
    #1;
    check_eq("reset_hold", 32'(got), 32'(r));
    rst = 1'b1;
    @(negedge clk);
    check_eq("init_cycle", 32'(got), 32'(r));
  endtask

  initial begin
    logic [4:0] op;
    int         r;
    do_reset();
    // Directed instructions: every defined opcode, both JZ flag values and one undefined opcode
    run_instr(5'd0, 1'b0, -1);
    run_instr(5'd1, 1'b0, -1);
    run_instr(5'd2, 1'b1, -1);
    run_instr(5'd3, 1'b0, -1);
    run_instr(5'd4, 1'b1, -1);
    run_instr(5'd5, 1'b1, -1);
    run_instr(5'd5, 1'b0, -1);
    run_instr(5'd9, 1'b1, -1);
    // Reset during E1 of MOV ACC,[DPTR]
    run_instr(5'd1, 1'b0, 5);
    // Randomised instruction stream (HALT excluded)
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) op = 5'(r);
      else op = 5'($urandom_range(0, 30));
      run_instr(op, 1'($urandom_range(0, 1)), -1);
    end
    // HALT held for 20 cycles, then reset recovers
    run_instr(5'd31, 1'b0, -1);
    do_reset();
    run_instr(5'd3, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
